// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter register and instruction fetch sequencer
module pc_fetch_ctrl #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [ADDR_W-1:0] o_pc,
    input  logic [ADDR_W-1:0] i_pc_plus4,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic              i_branch_taken,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [INST_W-1:0] i_imem_rdata,
    output logic              o_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    input  logic              i_inst_done,
    input  logic              i_halt,
    output logic              o_halted,
    output logic              o_error,
    output logic [31:0]       o_retire_cnt
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              next_misaligned;
    logic              cnt_at_max;

    // Successor PC comes from the external adders; only the select lives here.
    always_comb begin
        next_pc         = i_branch_taken ? i_branch_target : i_pc_plus4;
        next_misaligned = |next_pc[1:0];
        cnt_at_max      = &o_retire_cnt;
    end

    // Fetch address is the PC itself; it only moves on retirement, so it is
    // naturally stable for the whole request.
    assign o_pc        = pc;
    assign o_imem_addr = pc;

    // Fetch/execute sequencer with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            o_imem_req   <= 1'b0;
            o_inst_valid <= 1'b0;
            o_inst       <= '0;
            o_inst_pc    <= '0;
            o_halted     <= 1'b0;
            o_error      <= 1'b0;
            o_retire_cnt <= '0;
        end else begin
            case (state)
                S_BOOT: begin
                    state      <= S_FETCH;
                    o_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        o_inst       <= i_imem_rdata;
                        o_inst_pc    <= pc;
                        o_imem_req   <= 1'b0;
                        o_inst_valid <= 1'b1;
                        state        <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (i_inst_done) begin
                        o_inst_valid <= 1'b0;
                        if (next_misaligned) begin
                            // Misalignment beats halt: PC and count stay put.
                            o_error <= 1'b1;
                            state   <= S_ERROR;
                        end else begin
                            pc <= next_pc;
                            if (!cnt_at_max) begin
                                o_retire_cnt <= o_retire_cnt + 32'd1;
                            end
                            if (i_halt) begin
                                o_halted <= 1'b1;
                                state    <= S_HALT;
                            end else begin
                                o_imem_req <= 1'b1;
                                state      <= S_FETCH;
                            end
                        end
                    end
                end
                default: begin
                    // HALT and ERROR are terminal until reset.
                    o_imem_req   <= 1'b0;
                    o_inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic [63:0] branch_target;
    logic        branch_taken;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_done;
    logic        halt;
    logic        halted;
    logic        error;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        int          ack_dly;
        int          done_dly;
        logic        taken;
        logic [63:0] target;
        logic        hlt;
        logic [63:0] exp_addr;
        logic [63:0] exp_next;
        logic [31:0] exp_cnt;
        logic        exp_err;
        logic        exp_halted;
    } vec_t;

    pc_fetch_ctrl #(.ADDR_W(64), .INST_W(32), .RESET_PC(64'h0)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .o_pc            (pc),
        .i_pc_plus4      (pc_plus4),
        .i_branch_target (branch_target),
        .i_branch_taken  (branch_taken),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_ack      (imem_ack),
        .i_imem_rdata    (imem_rdata),
        .o_inst_valid    (inst_valid),
        .o_inst          (inst),
        .o_inst_pc       (inst_pc),
        .i_inst_done     (inst_done),
        .i_halt          (halt),
        .o_halted        (halted),
        .o_error         (error),
        .o_retire_cnt    (retire_cnt)
    );

    // External PC+4 adder model
    assign pc_plus4 = pc + 64'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One full fetch/execute/retire round trip; called at a falling edge.
    task automatic run_inst(input vec_t v);
        int waited = 0;
        while (!imem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("req_seen", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, v.exp_addr);
        repeat (v.ack_dly) @(negedge clk);
        chk("addr_held", imem_addr, v.exp_addr);
        imem_ack   = 1'b1;
        imem_rdata = v.rdata;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("valid_rise", inst_valid, 1'b1);
        chk("inst", inst, v.rdata);
        chk("inst_pc", inst_pc, v.exp_addr);
        chk("req_drop", imem_req, 1'b0);
        repeat (v.done_dly) @(negedge clk);
        chk("valid_hold", inst_valid, 1'b1);
        inst_done     = 1'b1;
        branch_taken  = v.taken;
        branch_target = v.target;
        halt          = v.hlt;
        @(negedge clk);
        inst_done     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        halt          = 1'b0;
        chk("valid_drop", inst_valid, 1'b0);
        chk("next_pc", pc, v.exp_next);
        chk("retire_cnt", retire_cnt, {32'h0, v.exp_cnt});
        chk("error", error, v.exp_err);
        chk("halted", halted, v.exp_halted);
    endtask

    // Terminal-state watch: no request, no valid, count/pc frozen, stray inputs ignored.
    task automatic watch_terminal(input logic [63:0] exp_pc, input logic [31:0] exp_cnt,
                                  input logic [31:0] exp_inst);
        int req_seen = 0;
        for (int i = 0; i < 8; i++) begin
            imem_ack   = (i == 2);
            imem_rdata = 32'hDEAD_BEEF;
            inst_done  = (i == 4);
            @(negedge clk);
            if (imem_req || inst_valid) req_seen++;
        end
        imem_ack  = 1'b0;
        inst_done = 1'b0;
        chk("term_no_req", req_seen, 0);
        chk("term_pc", pc, exp_pc);
        chk("term_cnt", retire_cnt, {32'h0, exp_cnt});
        chk("term_inst", inst, exp_inst);
    endtask

    vec_t tbl[4];
    vec_t v;

    initial begin
        tbl[0] = '{32'h1111_1111, 0, 2, 1'b0, 64'h0,   1'b0, 64'h0,   64'h4,   32'd1, 1'b0, 1'b0};
        tbl[1] = '{32'h2222_2222, 3, 2, 1'b0, 64'h0,   1'b0, 64'h4,   64'h8,   32'd2, 1'b0, 1'b0};
        tbl[2] = '{32'h3333_3333, 0, 2, 1'b1, 64'h100, 1'b0, 64'h8,   64'h100, 32'd3, 1'b0, 1'b0};
        tbl[3] = '{32'h4444_4444, 1, 0, 1'b0, 64'h0,   1'b0, 64'h100, 64'h104, 32'd4, 1'b0, 1'b0};

        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; inst_done = 1'b0;
        halt = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 64'h0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_cnt", retire_cnt, 64'h0);
        chk("rst_inst", inst, 64'h0);
        chk("rst_flags", {halted, error}, 2'b00);
        rst_n = 1'b1;
        #1;
        chk("boot_req", imem_req, 1'b0);
        @(negedge clk);
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 64'h0);

        // Sequential fetches and a taken branch
        for (int i = 0; i < 4; i++) run_inst(tbl[i]);

        // Misaligned branch target at 0x8 -> ERROR
        do_reset();
        run_inst(tbl[0]);
        run_inst(tbl[1]);
        v = '{32'h5555_5555, 0, 1, 1'b1, 64'h102, 1'b0, 64'h8, 64'h8, 32'd2, 1'b1, 1'b0};
        run_inst(v);
        watch_terminal(64'h8, 32'd2, 32'h5555_5555);
        chk("err_sticky", error, 1'b1);

        // Halt at 0x4
        do_reset();
        chk("reset_clears_err", error, 1'b0);
        run_inst(tbl[0]);
        v = '{32'h6666_6666, 0, 0, 1'b0, 64'h0, 1'b1, 64'h4, 64'h8, 32'd2, 1'b0, 1'b1};
        run_inst(v);
        watch_terminal(64'h8, 32'd2, 32'h6666_6666);
        chk("halt_sticky", halted, 1'b1);

        // Halt with misaligned target: error wins
        do_reset();
        v = '{32'h7777_7777, 0, 0, 1'b1, 64'h3, 1'b1, 64'h0, 64'h0, 32'd0, 1'b1, 1'b0};
        run_inst(v);

        // Reset while request pending at 0x40
        do_reset();
        v = '{32'h8888_8888, 0, 0, 1'b1, 64'h40, 1'b0, 64'h0, 64'h40, 32'd1, 1'b0, 1'b0};
        run_inst(v);
        @(negedge clk);
        chk("pend_req", imem_req, 1'b1);
        chk("pend_addr", imem_addr, 64'h40);
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", imem_req, 1'b0);
        chk("async_pc", pc, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req", imem_req, 1'b1);
        chk("restart_addr", imem_addr, 64'h0);
        run_inst(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
